// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns single-character ASCII commands into one-cycle
// requests for the servo PWM stage and returns one-byte ASCII status replies.
module uart_cmd_decoder #(
  parameter int TERM_TIMEOUT = 2_700_000,
  parameter int START_WIN    = 8,
  parameter int DONE_TIMEOUT = 135_000_000,
  parameter int CNT_W        = 28
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       moving_i,
  input  logic       target_reached_i,
  input  logic       tx_busy_i,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  output logic [2:0] state_desired_o,
  output logic       uart_command_valid_o,
  output logic       cmd_busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TERM,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_N = 8'h4E;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_X = 8'h58;

  // Last count value of each window; the event fires when the counter sits here.
  localparam logic [CNT_W-1:0] TERM_LAST  = CNT_W'(TERM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_WIN - 1);
  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_TIMEOUT - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       code_q;
  logic [2:0]       state_desired_q;
  logic             valid_q;
  logic             sticky_q;
  logic             push_q;
  logic [7:0]       push_byte_q;

  logic             cmd_hit;
  logic [2:0]       cmd_code;
  logic             is_term;

  // Reply FIFO storage and bookkeeping
  logic [7:0]       mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [7:0]       last_q;
  logic             pop;
  logic             push_ok;

  // Decode the received byte into a command code / terminator flag
  always_comb begin
    cmd_hit  = 1'b1;
    cmd_code = 3'b001;
    unique case (rx_data_i)
      8'h49, 8'h69: cmd_code = 3'b001;
      8'h44, 8'h64: cmd_code = 3'b010;
      8'h54, 8'h74: cmd_code = 3'b011;
      8'h2B:        cmd_code = 3'b100;
      8'h2D:        cmd_code = 3'b101;
      default:      cmd_hit  = 1'b0;
    endcase
    is_term = (rx_data_i == 8'h0D) || (rx_data_i == 8'h0A);
  end

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Command FSM: state, shared timeout counter, sticky done flag and reply requests
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      code_q          <= 3'b001;
      state_desired_q <= 3'b001;
      valid_q         <= 1'b0;
      sticky_q        <= 1'b0;
      push_q          <= 1'b0;
      push_byte_q     <= 8'h00;
    end else begin
      push_q  <= 1'b0;
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_valid_i) begin
            if (cmd_hit) begin
              code_q  <= cmd_code;
              cnt_q   <= '0;
              state_q <= S_TERM;
            end else if (!is_term) begin
              push_q      <= 1'b1;
              push_byte_q <= CH_E;
            end
          end
        end
        S_TERM: begin
          // Timeout has priority over a coincident byte, which is dropped.
          if (cnt_q >= TERM_LAST) begin
            push_q      <= 1'b1;
            push_byte_q <= CH_E;
            state_q     <= S_IDLE;
          end else if (rx_valid_i) begin
            if (is_term) begin
              sticky_q <= 1'b0;
              state_q  <= S_ISSUE;
            end else if (cmd_hit) begin
              code_q <= cmd_code;
              cnt_q  <= '0;
            end else begin
              push_q      <= 1'b1;
              push_byte_q <= CH_E;
              state_q     <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_ISSUE: begin
          if (moving_i) begin
            push_q      <= 1'b1;
            push_byte_q <= CH_B;
            state_q     <= S_IDLE;
          end else begin
            state_desired_q <= code_q;
            valid_q         <= 1'b1;
            sticky_q        <= target_reached_i;
            cnt_q           <= '0;
            state_q         <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          // A done pulse without a visible moving phase still counts as a start.
          if (moving_i || target_reached_i || sticky_q) begin
            push_q      <= 1'b1;
            push_byte_q <= CH_K;
            sticky_q    <= sticky_q | target_reached_i;
            cnt_q       <= '0;
            state_q     <= S_WAIT_DONE;
          end else if (cnt_q >= START_LAST) begin
            push_q      <= 1'b1;
            push_byte_q <= CH_N;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_WAIT_DONE: begin
          if (target_reached_i || sticky_q) begin
            push_q      <= 1'b1;
            push_byte_q <= CH_R;
            sticky_q    <= 1'b0;
            state_q     <= S_IDLE;
          end else if (cnt_q >= DONE_LAST) begin
            push_q      <= 1'b1;
            push_byte_q <= CH_X;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pop     = (count_q != 2'd0) && !tx_busy_i;
  assign push_ok = push_q && ((count_q != 2'd2) || pop);

  // Reply FIFO pointers, occupancy and the byte held after each send
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      last_q   <= 8'h00;
    end else begin
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        last_q   <= mem_q[rd_ptr_q];
      end
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Reply FIFO storage
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_byte_q;
  end

  assign tx_start_o           = pop;
  assign tx_data_o            = pop ? mem_q[rd_ptr_q] : last_q;
  assign state_desired_o      = state_desired_q;
  assign uart_command_valid_o = valid_q;
  assign cmd_busy_o           = (state_q != S_IDLE) && (state_q != S_TERM);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized bench for uart_cmd_decoder with a behavioural PWM stage and UART transmitter.
module tb_uart_cmd_decoder;
  localparam int TT = 50;
  localparam int SW = 8;
  localparam int DT = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       moving = 1'b0;
  logic       target = 1'b0;
  logic       force_busy = 1'b0;
  logic       model_busy = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [2:0] state_desired;
  logic       cmd_valid;
  logic       cmd_busy;

  assign tx_busy = model_busy | force_busy;

  uart_cmd_decoder #(.TERM_TIMEOUT(TT), .START_WIN(SW), .DONE_TIMEOUT(DT), .CNT_W(28)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .moving_i(moving), .target_reached_i(target), .tx_busy_i(tx_busy),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .state_desired_o(state_desired),
    .uart_command_valid_o(cmd_valid), .cmd_busy_o(cmd_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] obs_q [$];
  logic [2:0] obs_codes [$];
  logic [7:0] exp_q [$];
  logic [2:0] exp_codes [$];
  logic [2:0] last_code = 3'b001;
  logic [7:0] cmds [8] = '{8'h49, 8'h69, 8'h44, 8'h64, 8'h54, 8'h74, 8'h2B, 8'h2D};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] code_of(input logic [7:0] b);
    case (b)
      "I", "i": return 3'b001;
      "D", "d": return 3'b010;
      "T", "t": return 3'b011;
      "+":      return 3'b100;
      "-":      return 3'b101;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic bit is_special(input logic [7:0] b);
    return (code_of(b) != 3'b000) || (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic logic [7:0] rand_bad();
    logic [7:0] b;
    b = 8'($urandom);
    while (is_special(b)) b = 8'($urandom);
    return b;
  endfunction

  function automatic logic [7:0] rand_term();
    return ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
  endfunction

  // Transmitter model: records each started byte and stays busy a few cycles after it.
  initial begin : tx_monitor
    int  busy_cnt;
    logic prev_valid;
    logic start;
    busy_cnt   = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      start = tx_start;
      if (tx_start) begin
        obs_q.push_back(tx_data);
        check_eq("start_while_busy", 32'(tx_busy), 32'(0));
      end
      if (cmd_valid) begin
        obs_codes.push_back(state_desired);
        if (prev_valid) check_eq("valid_one_cycle", 32'(prev_valid), 32'(0));
      end
      prev_valid = cmd_valid;
      @(posedge clk);
      #1;
      if (start) busy_cnt = 1 + int'($urandom_range(0, 3));
      else if (busy_cnt > 0) busy_cnt--;
      model_busy = (busy_cnt > 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_eq("reply_arrival", 32'(obs_q.size() >= n), 32'(1));
  endtask

  task automatic wait_req();
    int k = 0;
    while (obs_codes.size() == 0 && k < 10) begin
      tick();
      k++;
    end
    check_eq("request_seen", 32'(obs_codes.size()), 32'(1));
  endtask

  task automatic finish_txn(input string tag);
    wait_bytes(exp_q.size(), 400);
    tick(6);
    check_eq({tag, "_nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check_eq({tag, "_nreq"}, 32'(obs_codes.size()), 32'(exp_codes.size()));
    for (int i = 0; i < exp_codes.size() && i < obs_codes.size(); i++)
      check_eq({tag, "_code"}, 32'(obs_codes[i]), 32'(exp_codes[i]));
    check_eq({tag, "_held"}, 32'(state_desired), 32'(last_code));
    check_eq({tag, "_idle"}, 32'(cmd_busy), 32'(0));
    $display("txn %s: replies=%0d requests=%0d code=%0d", tag, obs_q.size(), obs_codes.size(), last_code);
    obs_q.delete();
    exp_q.delete();
    obs_codes.delete();
    exp_codes.delete();
  endtask

  // kinds: 0 bad byte, 1 no terminator, 2 stray byte, 3 busy, 4 no move,
  //        5 move+done, 6 move+timeout, 7 done pulse only, 8 replaced command
  task automatic run_txn(input int kind, input logic [7:0] ch, input bit stall);
    int d;
    int l;
    string tag;
    tag = $sformatf("k%0d_%s", kind, ch);
    case (kind)
      0: begin send(rand_bad()); exp_q.push_back("E"); end
      1: begin send(ch); tick(TT + 10); exp_q.push_back("E"); end
      2: begin send(ch); tick($urandom_range(0, 20)); send(rand_bad()); exp_q.push_back("E"); end
      3: begin
        moving = 1'b1;
        tick();
        send(ch);
        tick($urandom_range(0, 20));
        send(rand_term());
        exp_q.push_back("B");
        wait_bytes(1, 40);
        moving = 1'b0;
      end
      default: begin
        if (kind == 8) begin
          send(cmds[$urandom_range(0, 7)]);
          tick($urandom_range(0, 10));
        end
        send(ch);
        tick($urandom_range(0, 20));
        send(rand_term());
        last_code = code_of(ch);
        exp_codes.push_back(last_code);
        wait_req();
        if (stall) force_busy = 1'b1;
        d = int'($urandom_range(1, 4));
        case (kind)
          5: begin
            l = stall ? 10 : int'($urandom_range(10, 150));
            tick(d);
            moving = 1'b1;
            tick(l / 2);
            send(8'($urandom));
            tick(l - l / 2);
            target = 1'b1;
            moving = 1'b0;
            tick();
            target = 1'b0;
            exp_q.push_back("K");
            exp_q.push_back("R");
          end
          6: begin
            tick(d);
            moving = 1'b1;
            exp_q.push_back("K");
            exp_q.push_back("X");
            wait_bytes(2, DT + 100);
            moving = 1'b0;
          end
          7: begin
            tick(2);
            target = 1'b1;
            tick();
            target = 1'b0;
            exp_q.push_back("K");
            exp_q.push_back("R");
          end
          default: exp_q.push_back("N");
        endcase
        if (stall) begin
          check_eq("stall_hold", 32'(obs_q.size()), 32'(0));
          tick(15);
          force_busy = 1'b0;
        end
      end
    endcase
    finish_txn(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx_data"}, 32'(tx_data), 32'(8'h00));
    check_eq({tag, "_tx_start"}, 32'(tx_start), 32'(0));
    check_eq({tag, "_state_desired"}, 32'(state_desired), 32'(3'b001));
    check_eq({tag, "_valid"}, 32'(cmd_valid), 32'(0));
    check_eq({tag, "_cmd_busy"}, 32'(cmd_busy), 32'(0));
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int kind;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    run_txn(5, "D", 1'b0);
    run_txn(3, "t", 1'b0);
    run_txn(4, "+", 1'b0);
    run_txn(1, "I", 1'b0);
    run_txn(4, "I", 1'b0);
    run_txn(5, "T", 1'b1);

    // Reset while waiting for the target: no 'R' may follow.
    send("D");
    tick(3);
    send(8'h0D);
    wait_req();
    tick(2);
    moving = 1'b1;
    wait_bytes(1, 20);
    if (obs_q.size() > 0) check_eq("rst_k", 32'(obs_q[0]), 32'("K"));
    check_eq("rst_code", 32'(obs_codes[0]), 32'(3'b010));
    tick(5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick(2);
    rst_n  = 1'b1;
    moving = 1'b0;
    target = 1'b1;
    tick();
    target = 1'b0;
    tick(30);
    check_eq("rst_no_r", 32'(obs_q.size()), 32'(1));
    $display("txn reset_mid_wait: replies=%0d", obs_q.size());
    obs_q.delete();
    obs_codes.delete();
    last_code = 3'b001;

    run_txn(6, "-", 1'b0);
    run_txn(7, "d", 1'b0);
    run_txn(8, "i", 1'b0);
    run_txn(0, "I", 1'b0);
    run_txn(2, "T", 1'b0);

    repeat (30) begin
      kind = int'($urandom_range(0, 8));
      run_txn(kind, cmds[$urandom_range(0, 7)], (kind == 5) && ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
